if_id_decode: RTL and testbench

IF_ID_DECODE -- requirements
Module: if_id_decode

---
 rtl/if_id_decode_pkg.sv | 41 ++++
 rtl/if_id_decode_imm_field_split.sv | 34 +++
 rtl/if_id_decode.sv | 133 +++++++++++++
 tb/tb_if_id_decode.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_decode_pkg.sv
// rtl/if_id_decode_pkg.sv - shared EXTOp encodings, opcode constants and NOP for IF/ID decode
// Purpose: single source of truth for the immediate-extender select codes,
//          the RV32 base opcodes that select them, and the canonical NOP.
// Ports:   none (package).
package if_id_decode_pkg;

  typedef enum logic [2:0] {
    EXT_NONE  = 3'b000,
    EXT_STYPE = 3'b001,
    EXT_ITYPE = 3'b010,
    EXT_BTYPE = 3'b100,
    EXT_UTYPE = 3'b101,
    EXT_JTYPE = 3'b110
  } extop_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  function automatic extop_e extop_of(input logic [6:0] opcode);
    extop_e w_sel;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: w_sel = EXT_ITYPE;
      OP_STORE:                 w_sel = EXT_STYPE;
      OP_BRANCH:                w_sel = EXT_BTYPE;
      OP_LUI, OP_AUIPC:         w_sel = EXT_UTYPE;
      OP_JAL:                   w_sel = EXT_JTYPE;
      default:                  w_sel = EXT_NONE;
    endcase
    return w_sel;
  endfunction

endpackage

// File: rtl/if_id_decode_imm_field_split.sv
// rtl/if_id_decode_imm_field_split.sv - combinational register/immediate field split and EXTOp select
// Purpose: slices a 32-bit instruction into register indices and raw
//          (unextended) immediate fields, and picks the extender mode.
// Ports:   in_instr (32) in; rs1/rs2/rd (5), iimm/simm/bimm (12),
//          iimm_shamt (5), uimm/jimm (20), EXTOp (3) out.
module imm_field_split
  import if_id_decode_pkg::*;
(
  input  logic [31:0] in_instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] iimm,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [2:0]  EXTOp
);

  assign rs1        = in_instr[19:15];
  assign rs2        = in_instr[24:20];
  assign rd         = in_instr[11:7];
  assign iimm       = in_instr[31:20];
  assign iimm_shamt = in_instr[24:20];
  assign simm       = {in_instr[31:25], in_instr[11:7]};
  // B and J immediates drop their always-zero LSB; the extender restores it.
  assign bimm       = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
  assign uimm       = in_instr[31:12];
  assign jimm       = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
  assign EXTOp      = extop_of(in_instr[6:0]);

endmodule

// File: rtl/if_id_decode.sv
// rtl/if_id_decode.sv - IF/ID pipeline register with valid/ready handshake and field decode
// Purpose: registers one fetched instruction/PC with latency 1, holds it
//          under backpressure, kills it on flush, and decodes fields from
//          the registered instruction.
// Ports:   clk, rstn (async active-low); in_valid/in_ready/in_instr/in_pc
//          from fetch; flush; out_valid/out_ready/out_pc/out_instr to
//          execute; rs1/rs2/rd, iimm, iimm_shamt, simm, bimm, uimm, jimm,
//          EXTOp decoded from out_instr.
// Config:  IFID_SKID_EN - adds a one-entry skid so in_ready is registered.
module if_id_decode
  import if_id_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [11:0] iimm,
  output logic [4:0]  iimm_shamt,
  output logic [11:0] simm,
  output logic [11:0] bimm,
  output logic [19:0] uimm,
  output logic [19:0] jimm,
  output logic [2:0]  EXTOp
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        w_accept;
  logic        w_out_fire;

  assign w_out_fire = r_valid && out_ready;

`ifdef IFID_SKID_EN
  logic        r_sk_full;
  logic        r_in_ready;
  logic [31:0] r_sk_instr;
  logic [31:0] r_sk_pc;

  assign in_ready = r_in_ready;
  assign w_accept = in_valid && r_in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc       <= 32'h0;
      r_sk_full  <= 1'b0;
      r_in_ready <= 1'b1;
      r_sk_instr <= NOP_INSTR;
      r_sk_pc    <= 32'h0;
    end else if (flush) begin
      // Flush beats any simultaneous acceptance; the PC is left as is.
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_sk_full  <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (r_sk_full) begin
      // Output is necessarily valid here; refill it from the skid on a take.
      if (out_ready) begin
        r_instr    <= r_sk_instr;
        r_pc       <= r_sk_pc;
        r_sk_full  <= 1'b0;
        r_in_ready <= 1'b1;
      end
    end else if (w_accept) begin
      if (!r_valid || out_ready) begin
        r_valid <= 1'b1;
        r_instr <= in_instr;
        r_pc    <= in_pc;
      end else begin
        r_sk_instr <= in_instr;
        r_sk_pc    <= in_pc;
        r_sk_full  <= 1'b1;
        r_in_ready <= 1'b0;
      end
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
    end else if (flush) begin
      // Flush beats any simultaneous acceptance; the PC is left as is.
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_instr <= in_instr;
      r_pc    <= in_pc;
    end else if (w_out_fire) begin
      // Contents are kept after the take; only the valid flag drops.
      r_valid <= 1'b0;
    end
  end
`endif

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_pc    = r_pc;

  imm_field_split u_split (
    .in_instr   (r_instr),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .iimm       (iimm),
    .iimm_shamt (iimm_shamt),
    .simm       (simm),
    .bimm       (bimm),
    .uimm       (uimm),
    .jimm       (jimm),
    .EXTOp      (EXTOp)
  );

endmodule

// File: tb/tb_if_id_decode.sv
// tb/tb_if_id_decode.sv - self-checking bench for if_id_decode
module tb_if_id_decode;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  rs1, rs2, rd, iimm_shamt;
  logic [11:0] iimm, simm, bimm;
  logic [19:0] uimm, jimm;
  logic [2:0]  EXTOp;

  if_id_decode dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .rs1(rs1), .rs2(rs2), .rd(rd), .iimm(iimm), .iimm_shamt(iimm_shamt),
    .simm(simm), .bimm(bimm), .uimm(uimm), .jimm(jimm), .EXTOp(EXTOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: the block is a FIFO of accepted, not-yet-taken entries.
  // Head is what the output shows; capacity is 1 (2 with the skid).
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] dq[$];

`ifdef IFID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  function automatic logic [2:0] exp_ext(input logic [6:0] op);
    case (op)
      7'h13, 7'h03, 7'h67: return 3'b010;
      7'h23:               return 3'b001;
      7'h63:               return 3'b100;
      7'h37, 7'h17:        return 3'b101;
      7'h6F:               return 3'b110;
      default:             return 3'b000;
    endcase
  endfunction

  function automatic logic m_in_ready(input logic ordy);
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || ordy;
  endfunction

  task automatic model_reset();
    q.delete();
    m_instr = 32'h00000013;
    m_pc    = 32'h0;
  endtask

  task automatic check_outputs();
    logic [31:0] i;
    i = m_instr;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_instr", out_instr, i);
    chk("out_pc", out_pc, m_pc);
    chk("rs1", 32'(rs1), 32'(i[19:15]));
    chk("rs2", 32'(rs2), 32'(i[24:20]));
    chk("rd", 32'(rd), 32'(i[11:7]));
    chk("iimm", 32'(iimm), 32'(i[31:20]));
    chk("shamt", 32'(iimm_shamt), 32'(i[24:20]));
    chk("simm", 32'(simm), 32'({i[31:25], i[11:7]}));
    chk("bimm", 32'(bimm), 32'({i[31], i[7], i[30:25], i[11:8]}));
    chk("uimm", 32'(uimm), 32'(i[31:12]));
    chk("jimm", 32'(jimm), 32'({i[31], i[19:12], i[20], i[30:21]}));
    chk("EXTOp", 32'(EXTOp), 32'(exp_ext(i[6:0])));
  endtask

  // One clock: called at a negedge, returns at the next negedge.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                     input logic ordy, input logic fl, output logic acc);
    logic er;
    logic fire;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    #1;
    er = m_in_ready(ordy);
    chk("in_ready", 32'(in_ready), 32'(er));
    acc  = iv && er;
    fire = (q.size() > 0) && ordy;
    if (out_valid && out_ready) dq.push_back(out_instr);
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_instr = 32'h00000013;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) q.push_back('{instr: ins, pc: p});
      if (q.size() > 0) begin
        m_instr = q[0].instr;
        m_pc    = q[0].pc;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  logic        a;
  logic [31:0] abc [3];
  int          idx;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    flush = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h00000013);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_EXTOp", 32'(EXTOp), 32'(3'b010));
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    // addi x1,x0,5
    cyc(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, a);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_EXTOp", 32'(EXTOp), 32'(3'b010));
    chk("addi_iimm", 32'(iimm), 32'h005);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_pc", out_pc, 32'h100);
    // sw x1,-4(x2)
    cyc(1'b1, 32'hFE112E23, 32'h104, 1'b1, 1'b0, a);
    chk("sw_EXTOp", 32'(EXTOp), 32'(3'b001));
    chk("sw_simm", 32'(simm), 32'hFFC);
    chk("sw_rs1", 32'(rs1), 32'd2);
    chk("sw_rs2", 32'(rs2), 32'd1);
    // jal x0,8
    cyc(1'b1, 32'h0080006F, 32'h108, 1'b1, 1'b0, a);
    chk("jal_EXTOp", 32'(EXTOp), 32'(3'b110));
    chk("jal_jimm", 32'(jimm), 32'h00004);
    // beq x0,x0,-4
    cyc(1'b1, 32'hFE000EE3, 32'h10C, 1'b1, 1'b0, a);
    chk("beq_EXTOp", 32'(EXTOp), 32'(3'b100));
    chk("beq_bimm", 32'(bimm), 32'hFFE);
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);

    // Stall: stream A,B,C with out_ready low for 3 cycles after A lands.
    abc = '{32'h00100113, 32'h00200193, 32'h00300213};
    dq.delete();
    idx = 0;
    for (int k = 0; k < 20 && !(idx == 3 && q.size() == 0); k++) begin
      cyc(idx < 3, (idx < 3) ? abc[idx] : 32'h0, 32'h200 + 32'(idx * 4),
          !(k >= 1 && k <= 3), 1'b0, a);
      if (a) idx++;
      if (k == 3) begin
        chk("stall_hold_A", out_instr, abc[0]);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    chk("stall_count", 32'(dq.size()), 32'd3);
    for (int j = 0; j < 3; j++)
      chk("stall_order", (j < dq.size()) ? dq[j] : 32'hDEAD_DEAD, abc[j]);

    // Flush with a valid output and a simultaneous offer.
    cyc(1'b1, 32'h00700293, 32'h300, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h00800313, 32'h304, 1'b1, 1'b1, a);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_instr", out_instr, 32'h00000013);
    chk("flush_EXTOp", 32'(EXTOp), 32'(3'b010));
    chk("flush_pc", out_pc, 32'h300);
    dq.delete();
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a);
    chk("flush_dropped", 32'(dq.size()), 32'd0);

    // Asynchronous reset in the middle of a stall.
    cyc(1'b1, 32'h00900393, 32'h400, 1'b0, 1'b0, a);
    cyc(1'b1, 32'h00A00413, 32'h404, 1'b0, 1'b0, a);
    #3 rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_instr", out_instr, 32'h00000013);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    check_outputs();

    // Randomised traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom,
          $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, a);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
